// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between the fetch and data requesters.
// Data side wins ties until the starvation counter forces a fetch grant.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // state | meaning
  // IDLE  | ready offered to at most one requester, waiting for a handshake
  // ISSUE | single mem_en cycle for the latched command
  // WAIT  | latency down-counter running; terminal count returns data and ack
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int CNT_W = 3;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT - 1);
  localparam logic [ST_W-1:0]  STARVE_LIM = ST_W'(STARVE_MAX);

  state_t            state;
  logic [CNT_W-1:0]  lat_cnt;
  logic [ST_W-1:0]   starve;
  logic              owner_dm;
  logic              owner_we;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              force_if;
  logic              grant_if;
  logic              grant_dm;
  logic              done;

  always_comb begin
    force_if = (starve == STARVE_LIM);
    grant_if = !reset && (state == IDLE) && if_req && (!dm_req || force_if);
    grant_dm = !reset && (state == IDLE) && dm_req && !(if_req && force_if);
    done     = !reset && (state == WAIT) && (lat_cnt == '0);
  end

  assign if_ready  = grant_if;
  assign dm_ready  = grant_dm;
  assign if_rvalid = done && !owner_dm;
  assign dm_rvalid = done && owner_dm;

  // Read data is only valid in the terminal-count cycle, so it is passed through
  // combinationally then and held from the capture register afterwards.
  assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
  assign dm_rdata = (dm_rvalid && !owner_we) ? mem_rdata : dm_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve     <= '0;
      owner_dm   <= 1'b0;
      owner_we   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if || grant_dm) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            mem_en   <= 1'b1;
            owner_dm <= grant_dm;
            owner_we <= grant_dm && dm_we;
            mem_we   <= grant_dm && dm_we;
            mem_addr <= grant_dm ? dm_addr : if_addr;
            if (grant_dm) mem_wdata <= dm_wdata;
            if (grant_if || !if_req) starve <= '0;
            else if (starve != STARVE_LIM) starve <= starve + 1'b1;
          end
        end
        ISSUE: begin
          mem_en  <= 1'b0;
          lat_cnt <= LAT_LOAD;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state  <= IDLE;
            busy   <= 1'b0;
            mem_we <= 1'b0;
            if (!owner_dm) if_rdata_q <= mem_rdata;
            else if (!owner_we) dm_rdata_q <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: a cycle-level reference model predicts
// grants, memory commands and responses; a separate monitor checks what the DUT presents.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 4;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_ready, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic              dm_ready, dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- memory contents: behavioural memory and reference copy
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] tb_mem  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] tb_rd(input logic [31:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    tb_mem[a]  = d;
    ref_mem[a] = d;
  endtask

  // synchronous memory: data appears MEM_LAT cycles after the mem_en cycle, junk otherwise
  logic [31:0] rd_pipe [MEM_LAT];
  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && !mem_we) rd_pipe[0] <= tb_rd(mem_addr);
    else rd_pipe[0] <= $urandom;
    if (mem_en && mem_we) tb_mem[mem_addr] = mem_wdata;
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // ---------------- reference model and scoreboard queues
  typedef struct {
    int          at;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          at;
    bit          dm;
    bit          we;
    logic [31:0] data;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  bit   grant_log[$];

  int free_cyc = 0;
  int busy_lo  = 0;
  int busy_hi  = -1;
  int starve_m = 0;

  always @(negedge clk) begin
    bit   idle, gi, gd;
    cmd_t c;
    rsp_t r;
    if (reset) begin
      cmd_q.delete();
      rsp_q.delete();
      free_cyc = cyc + 1;
      busy_lo  = cyc + 1;
      busy_hi  = cyc;
      starve_m = 0;
      chk("ready_during_reset", 64'({if_ready, dm_ready}), 64'(2'b00));
    end else begin
      idle = (cyc >= free_cyc);
      gi   = idle && if_req && (!dm_req || starve_m == STARVE_MAX);
      gd   = idle && dm_req && !gi;
      chk("if_ready", 64'(if_ready), 64'(gi));
      chk("dm_ready", 64'(dm_ready), 64'(gd));
      chk("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
      if (gi || gd) begin
        free_cyc = cyc + MEM_LAT + 2;
        busy_lo  = cyc + 1;
        busy_hi  = cyc + 1 + MEM_LAT;
        c.at = cyc + 1;
        r.at = cyc + 1 + MEM_LAT;
        if (gi) begin
          c.we = 1'b0; c.addr = if_addr; c.wdata = '0;
          r.dm = 1'b0; r.we = 1'b0; r.data = ref_rd(if_addr);
          starve_m = 0;
          grant_log.push_back(1'b0);
        end else begin
          c.we = dm_we; c.addr = dm_addr; c.wdata = dm_wdata;
          r.dm = 1'b1; r.we = dm_we; r.data = ref_rd(dm_addr);
          if (dm_we) ref_mem[dm_addr] = dm_wdata;
          starve_m = if_req ? ((starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX) : 0;
          grant_log.push_back(1'b1);
        end
        cmd_q.push_back(c);
        rsp_q.push_back(r);
      end
    end
  end

  // ---------------- monitor
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;
  bit          prev_rst = 1'b1;

  always @(negedge clk) begin
    cmd_t c;
    rsp_t r;
    if (reset) begin
      prev_rst     = 1'b1;
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
    end else begin
      if (prev_rst) begin
        chk("post_reset_ctrl", 64'({mem_en, mem_we, busy, if_rvalid, dm_rvalid}), 64'(5'b0));
        chk("post_reset_data", 64'(|{mem_addr, mem_wdata, if_rdata, dm_rdata}), 64'(1'b0));
        prev_rst = 1'b0;
      end
      if (mem_en) begin
        if (cmd_q.size() == 0) begin
          chk("mem_en_unexpected", 64'(mem_en), 64'(1'b0));
        end else begin
          c = cmd_q.pop_front();
          chk("mem_en_cycle", 64'(cyc), 64'(c.at));
          chk("mem_we", 64'(mem_we), 64'(c.we));
          chk("mem_addr", 64'(mem_addr), 64'(c.addr));
          if (c.we) chk("mem_wdata", 64'(mem_wdata), 64'(c.wdata));
        end
      end else if (cmd_q.size() > 0 && cmd_q[0].at < cyc) begin
        chk("mem_en_missing", 64'(cyc), 64'(cmd_q[0].at));
        void'(cmd_q.pop_front());
      end
      if (if_rvalid || dm_rvalid) begin
        chk("rvalid_exclusive", 64'(if_rvalid & dm_rvalid), 64'(1'b0));
        if (rsp_q.size() == 0) begin
          chk("rvalid_unexpected", 64'({if_rvalid, dm_rvalid}), 64'(2'b00));
        end else begin
          r = rsp_q.pop_front();
          chk("rvalid_cycle", 64'(cyc), 64'(r.at));
          chk("rvalid_port", 64'({if_rvalid, dm_rvalid}), r.dm ? 64'(2'b01) : 64'(2'b10));
          if (!r.dm) exp_if_rdata = r.data;
          else if (!r.we) exp_dm_rdata = r.data;
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].at < cyc) begin
        chk("rvalid_missing", 64'(cyc), 64'(rsp_q[0].at));
        void'(rsp_q.pop_front());
      end
      chk("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
      chk("dm_rdata", 64'(dm_rdata), 64'(exp_dm_rdata));
    end
  end

  // ---------------- requester drivers (called aligned to posedge + 1)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait();
    repeat (MEM_LAT + 3) step();
  endtask

  task automatic if_xact(input logic [31:0] a);
    int w;
    w = 0;
    if_req  = 1'b1;
    if_addr = a;
    do begin
      @(negedge clk);
      w++;
    end while (!if_ready && w < 200);
    chk("if_handshake", 64'(if_ready), 64'(1'b1));
    step();
    if_req = 1'b0;
  endtask

  task automatic dm_xact(input logic we, input logic [31:0] a, input logic [31:0] d);
    int w;
    w = 0;
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = d;
    do begin
      @(negedge clk);
      w++;
    end while (!dm_ready && w < 200);
    chk("dm_handshake", 64'(dm_ready), 64'(1'b1));
    step();
    dm_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    return $urandom_range(0, 31) << 2;
  endfunction

  task automatic rand_if(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 9) == 0) begin
        if_req  = 1'b1;
        if_addr = rand_addr();
        step();
        if_req = 1'b0;
      end else begin
        if_xact(rand_addr());
      end
    end
  endtask

  task automatic rand_dm(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 9) == 0) begin
        dm_req   = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = rand_addr();
        dm_wdata = $urandom;
        step();
        dm_req = 1'b0;
      end else begin
        dm_xact(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // single fetch with known data
    preload(32'h10, 32'hA5A5_0001);
    if_xact(32'h10);
    idle_wait();
    chk("fetch_0x10_data", 64'(if_rdata), 64'(32'hA5A5_0001));

    // simultaneous fetch and load: data first, fetch right after
    grant_log.delete();
    fork
      if_xact(32'h14);
      dm_xact(1'b0, 32'h40, 32'h0);
    join
    idle_wait();
    chk("tie_grant_count", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() == 2) begin
      chk("tie_first_is_dm", 64'(grant_log[0]), 64'(1'b1));
      chk("tie_second_is_if", 64'(grant_log[1]), 64'(1'b0));
    end

    // store then load back
    dm_xact(1'b1, 32'h20, 32'hDEAD_BEEF);
    idle_wait();
    dm_xact(1'b0, 32'h20, 32'h0);
    idle_wait();
    chk("load_after_store", 64'(dm_rdata), 64'(32'hDEAD_BEEF));

    // both requesters held continuously: starvation forces every (STARVE_MAX+1)th grant
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 2 * STARVE_MAX; i++) dm_xact(1'b0, 32'h100 + 32'(i * 4), 32'h0);
      end
      begin
        for (int i = 0; i < 2; i++) if_xact(32'h200 + 32'(i * 4));
      end
    join
    idle_wait();
    chk("starve_grant_count", 64'(grant_log.size()), 64'(2 * STARVE_MAX + 2));
    for (int k = 0; k < grant_log.size() && k < 2 * STARVE_MAX + 2; k++)
      chk($sformatf("starve_order_%0d", k), 64'(grant_log[k]), 64'((k % (STARVE_MAX + 1)) != STARVE_MAX));

    // reset part-way through WAIT drops the fetch; new fetch accepted straight after
    if_xact(32'h30);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h34;
    @(negedge clk);
    chk("if_ready_after_reset", 64'(if_ready), 64'(1'b1));
    step();
    if_req = 1'b0;
    idle_wait();

    // random traffic from both sides
    fork
      rand_if(60);
      rand_dm(60);
    join
    idle_wait();
    chk("cmd_queue_drained", 64'(cmd_q.size()), 64'(0));
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
